fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Fetch-stage PC register and IF/ID pipeline register. Consumes the redirect request from the decode-stage PC logic (PC_Sel, PC_Ex) and drives the instruction-memory request with a ready handshake. Holds one fetched instruction across hazard stalls and stops issuing fetches after a fetched HALT. Output feeds the decode stage; IF_ID_PC2 is the PC2 input of the decode-stage PC logic.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset.
NOP_INST, 16'h0800, instruction placed in IF/ID on a bubble.
HALT_OP, 5'b00000, opcode in Inst[15:11] that identifies HALT.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
PC_Sel  in  1  redirect request from decode; qualified by !Stall.
PC_Ex  in  16  redirect target.
Stall  in  1  hazard-unit stall; IF/ID and PC hold.
Mem_Ready  in  1  Mem_Inst valid this cycle.
Mem_Inst  in  16  instruction from memory.
Mem_Req  out  1  fetch request.
Mem_Addr  out  16  fetch address, equal to the PC register.
IF_ID_Inst  out  16  registered instruction to decode.
IF_ID_PC2  out  16  registered fetch address + 2.
IF_ID_Valid  out  1  IF/ID holds a real instruction.
Halted  out  1  high while in HALTED.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; state=FETCH.
  - IF_ID_Inst=NOP_INST, IF_ID_PC2=0, IF_ID_Valid=0.
  - Buffer empty; pending flag=0; Halted=0.
- Redirect = PC_Sel & !Stall. Priority: reset > redirect > Stall > normal.
- Mem_Req = (state==FETCH), combinational. Mem_Addr = PC, stable while Mem_Req=1 and Mem_Ready=0.
- PC+2 is a 16-bit wrapping add: FFFE -> 0000.
- "Bubble" means IF_ID <= {NOP_INST, PC2 unchanged, Valid=0}.
- States: FETCH, HOLD, HALTED.
- FETCH, Mem_Ready=1:
  - Redirect or pending set: discard Mem_Inst; PC<=PC_Ex (redirect) or pending target; clear pending; bubble if redirect; stay in FETCH.
  - Else if Stall: buffer<={Mem_Inst, PC+2}; PC<=PC+2; go to HOLD.
  - Else: IF_ID<={Mem_Inst, PC+2, 1}; PC<=PC+2. If Mem_Inst[15:11]==HALT_OP, go to HALTED.
- FETCH, Mem_Ready=0:
  - Redirect: pending<=1; target<=PC_Ex; bubble; PC unchanged.
  - Else if !Stall: bubble.
  - Else (Stall): hold everything.
- HOLD (Mem_Req=0):
  - Redirect: drop buffer; PC<=PC_Ex; bubble; go to FETCH.
  - Else if !Stall: IF_ID<=buffer with Valid=1; go to HALTED if the buffered instruction is HALT, else FETCH.
  - Else: stay in HOLD.
- HALTED (Mem_Req=0, Halted=1):
  - Bubble each cycle when !Stall.
  - Redirect: PC<=PC_Ex; bubble; go to FETCH (a HALT in a branch shadow is cancelled).
- A redirect with Stall=1 is ignored; decode must keep PC_Sel asserted until the stall clears.
- Latency: Mem_Ready in cycle N, Stall=0 -> IF_ID valid at edge ending cycle N. Zero-wait memory sustains 1 instruction/cycle.
- Reset mid-WAIT or mid-HOLD: buffer and pending are discarded, no completion. A Mem_Ready arriving in the first cycle after reset is accepted as the RESET_PC fetch.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs Perf_Fetched[15:0] (count of instructions written valid into IF/ID) and Perf_Redirects[15:0] (count of cycles with Redirect=1). Both are saturating at FFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: state enum (FETCH, HOLD, HALTED), NOP_INST/HALT_OP defaults, opcode field position [15:11].
- Sub-module fetch_skid_buf: one-entry {Inst, PC2} buffer with load/drain/flush and valid flag. The top level keeps the FSM, PC and pending-redirect logic.

Test Plan:
- Zero-wait memory, Mem_Inst=1111 then 2222 from PC 0000 -> IF_ID (1111, 0002, 1) then (2222, 0004, 1); Mem_Addr 0000, 0002, 0004.
- Stall=1 while Mem_Ready=1 returns 3333 at PC 0010 -> state HOLD, Mem_Req=0, IF_ID unchanged. Release Stall -> IF_ID=(3333, 0012, 1), Mem_Addr=0012.
- Mem_Ready=0 at PC 0020; PC_Sel=1 with PC_Ex=0100, then Mem_Ready=1 with 4444 -> 4444 dropped, IF_ID bubble, next Mem_Addr=0100.
- Fetch 0000 (HALT) at 0030 -> IF_ID valid HALT, Halted=1, Mem_Req=0. Then PC_Sel=1 with PC_Ex=0040 -> Halted=0, Mem_Addr=0040.
- PC=FFFE, fetch succeeds -> IF_ID_PC2=0000, next Mem_Addr=0000.
- rst_n pulsed low in HOLD -> outputs return to reset values immediately; first fetch after release is from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch-stage PC unit
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NOP_INST_DEF = 16'h0800;
    localparam logic [4:0]  HALT_OP_DEF  = 5'b00000;
    localparam int          OPC_MSB      = 15;
    localparam int          OPC_LSB      = 11;

    function automatic logic is_halt(input logic [15:0] inst, input logic [4:0] halt_op);
        return inst[OPC_MSB:OPC_LSB] == halt_op;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {inst, pc2} holding buffer for stalled fetches
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [15:0] load_inst,
    input  logic [15:0] load_pc2,
    output logic        buf_valid,
    output logic [15:0] buf_inst,
    output logic [15:0] buf_pc2
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_inst  <= 16'h0000;
            buf_pc2   <= 16'h0000;
        end else if (flush || drain) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_inst  <= load_inst;
            buf_pc2   <= load_pc2;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register and IF/ID register; FETCH_PERF_EN adds perf counters
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = NOP_INST_DEF,
    parameter logic [4:0]  HALT_OP  = HALT_OP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Sel,
    input  logic [15:0] PC_Ex,
    input  logic        Stall,
    input  logic        Mem_Ready,
    input  logic [15:0] Mem_Inst,
    output logic        Mem_Req,
    output logic [15:0] Mem_Addr,
    output logic [15:0] IF_ID_Inst,
    output logic [15:0] IF_ID_PC2,
    output logic        IF_ID_Valid,
`ifdef FETCH_PERF_EN
    output logic [15:0] Perf_Fetched,
    output logic [15:0] Perf_Redirects,
`endif
    output logic        Halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_inc;
    logic         pending;
    logic [15:0]  pend_target;
    logic         redirect;
    logic         accept_new;
    logic         buf_load;
    logic         buf_drain;
    logic         buf_flush;
    logic         buf_valid;
    logic [15:0]  buf_inst;
    logic [15:0]  buf_pc2;

    assign redirect = PC_Sel & ~Stall;
    assign pc_inc   = pc + 16'd2;
    assign Mem_Req  = (state == ST_FETCH);
    assign Mem_Addr = pc;

    // A returning fetch is usable only if no redirect is live or queued behind it.
    assign accept_new = (state == ST_FETCH) & Mem_Ready & ~redirect & ~pending;
    assign buf_load   = accept_new & Stall;
    assign buf_drain  = (state == ST_HOLD) & ~redirect & ~Stall & buf_valid;
    assign buf_flush  = (state == ST_HOLD) & redirect;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .drain     (buf_drain),
        .flush     (buf_flush),
        .load_inst (Mem_Inst),
        .load_pc2  (pc_inc),
        .buf_valid (buf_valid),
        .buf_inst  (buf_inst),
        .buf_pc2   (buf_pc2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pend_target <= 16'h0000;
            IF_ID_Inst  <= NOP_INST;
            IF_ID_PC2   <= 16'h0000;
            IF_ID_Valid <= 1'b0;
            Halted      <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (Mem_Ready) begin
                        if (redirect || pending) begin
                            pc      <= redirect ? PC_Ex : pend_target;
                            pending <= 1'b0;
                            if (redirect) begin
                                IF_ID_Inst  <= NOP_INST;
                                IF_ID_Valid <= 1'b0;
                            end
                        end else if (Stall) begin
                            pc    <= pc_inc;
                            state <= ST_HOLD;
                        end else begin
                            IF_ID_Inst  <= Mem_Inst;
                            IF_ID_PC2   <= pc_inc;
                            IF_ID_Valid <= 1'b1;
                            pc          <= pc_inc;
                            if (is_halt(Mem_Inst, HALT_OP)) begin
                                state  <= ST_HALTED;
                                Halted <= 1'b1;
                            end
                        end
                    end else if (redirect) begin
                        pending     <= 1'b1;
                        pend_target <= PC_Ex;
                        IF_ID_Inst  <= NOP_INST;
                        IF_ID_Valid <= 1'b0;
                    end else if (!Stall) begin
                        IF_ID_Inst  <= NOP_INST;
                        IF_ID_Valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc          <= PC_Ex;
                        IF_ID_Inst  <= NOP_INST;
                        IF_ID_Valid <= 1'b0;
                        state       <= ST_FETCH;
                    end else if (!Stall) begin
                        IF_ID_Inst  <= buf_inst;
                        IF_ID_PC2   <= buf_pc2;
                        IF_ID_Valid <= 1'b1;
                        if (is_halt(buf_inst, HALT_OP)) begin
                            state  <= ST_HALTED;
                            Halted <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    if (redirect) begin
                        pc          <= PC_Ex;
                        IF_ID_Inst  <= NOP_INST;
                        IF_ID_Valid <= 1'b0;
                        state       <= ST_FETCH;
                        Halted      <= 1'b0;
                    end else if (!Stall) begin
                        IF_ID_Inst  <= NOP_INST;
                        IF_ID_Valid <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_FETCH;
                    Halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Perf_Fetched   <= 16'h0000;
            Perf_Redirects <= 16'h0000;
        end else begin
            if (((accept_new & ~Stall) | buf_drain) && Perf_Fetched != 16'hFFFF)
                Perf_Fetched <= Perf_Fetched + 16'd1;
            if (redirect && Perf_Redirects != 16'hFFFF)
                Perf_Redirects <= Perf_Redirects + 16'd1;
        end
    end
`endif

endmodule
